cdc_pulse_req_ctrl: RTL



---
 rtl/cdc_pulse_req_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/cdc_pulse_req_ctrl.sv
// cdc_pulse_req_ctrl
//
// Fast-domain request controller in front of a toggle-based fast-to-slow pulse
// synchronizer. Local request strobes are counted into a pending queue and
// issued one at a time as single-cycle pulses. The next pulse is held back
// until the previous one is acknowledged (ack returned through the slow-to-fast
// pulse synchronizer) or abandoned after TIMEOUT cycles. This keeps issued
// pulses further apart than the synchronizer round trip.
//
// Parameters:
//   CNT_W    width of the pending counter, max queued = 2^CNT_W-1
//   TIMEOUT  max cycles spent waiting for an ack (>= 2)
//   TO_W     timer width, 2^TO_W > TIMEOUT
//
// Ports:
//   clk        fast-domain clock, rising edge
//   rst_n      synchronous active-low reset
//   req_in     single-cycle request strobe, one request per high cycle
//   ack_in     single-cycle ack pulse from the return synchronizer
//   err_clr    clears the sticky err flag
//   req_pulse  single-cycle pulse toward the fast-to-slow synchronizer
//   busy       high while a request is in flight or queued
//   pending    queued, not-yet-issued requests
//   done       one-cycle pulse: issued request acknowledged
//   timeout    one-cycle pulse: issued request abandoned
//   overflow   one-cycle pulse: request dropped, counter saturated
//   err        sticky: timeout, overflow or spurious ack seen

module cdc_pulse_req_ctrl #(
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned TO_W    = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_in,
    input  logic             ack_in,
    input  logic             err_clr,
    output logic             req_pulse,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             done,
    output logic             timeout,
    output logic             overflow,
    output logic             err
);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWaitAck
    } state_e;

    localparam logic [TO_W-1:0] TimerLast = TO_W'(TIMEOUT - 1);

    state_e          state;
    logic [TO_W-1:0] timer;

    logic in_wait;
    logic dec;
    logic sat;
    logic inc;
    logic drop;
    logic expire;
    logic spurious;
    logic err_set;

    always_comb begin
        in_wait  = (state == StWaitAck);
        // The queued request is consumed on the SEND -> WAIT_ACK edge.
        dec      = (state == StSend);
        sat      = &pending;
        // At saturation a same-cycle decrement frees a slot, so the request fits.
        inc      = req_in && (!sat || dec);
        drop     = req_in && sat && !dec;
        // Ack wins over an expiring timer.
        expire   = in_wait && !ack_in && (timer == TimerLast);
        spurious = ack_in && !in_wait;
        err_set  = expire || drop || spurious;
    end

    assign busy = (state != StIdle) || (pending != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            timer     <= '0;
            pending   <= '0;
            req_pulse <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            overflow  <= 1'b0;
            err       <= 1'b0;
        end else begin
            req_pulse <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            overflow  <= drop;

            case (state)
                StIdle: begin
                    if (pending != '0) begin
                        state     <= StSend;
                        req_pulse <= 1'b1;
                    end
                end
                StSend: begin
                    state <= StWaitAck;
                    timer <= '0;
                end
                StWaitAck: begin
                    if (ack_in) begin
                        state <= StIdle;
                        done  <= 1'b1;
                    end else if (timer == TimerLast) begin
                        state   <= StIdle;
                        timeout <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase

            case ({inc, dec})
                2'b10:   pending <= pending + 1'b1;
                2'b01:   pending <= pending - 1'b1;
                default: pending <= pending;
            endcase

            // Set has priority over clear.
            if (err_set) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule
